reg_writeback: RTL

- Writer-side companion to the register file: sole owner and driver of its single write port (w_en, wa3, wd3).
- Merges results from two producers into one registered write per cycle:
  - the single-cycle ALU;
  - the multi-cycle load unit, whose returns are buffered in a small FIFO.
- Keeps a per-register pending scoreboard. The issue stage uses it to stall on RAW hazards against in-flight results.

---
 rtl/reg_writeback_pkg.sv | 11 +
 rtl/reg_writeback_if.sv | 41 ++++
 rtl/reg_writeback_wb_fifo.sv | 61 ++++++
 rtl/reg_writeback.sv | 97 +++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared constants for the register-file writeback block: word/address widths
// and the load-return queue geometry.
package reg_writeback_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NREGS          = 1 << REG_ADDR_WIDTH;
    localparam int LQ_DEPTH       = 4;
    localparam int LQ_CNT_WIDTH   = $clog2(LQ_DEPTH) + 1;

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle of producer handshakes, issue-side scoreboard access and the
// register-file write port; the writeback block is the slave side.
interface reg_writeback_if;
    import reg_writeback_pkg::*;

    logic                      alu_valid;
    logic                      alu_ready;
    logic [REG_ADDR_WIDTH-1:0] alu_rd;
    logic [WORD_WIDTH-1:0]     alu_data;

    logic                      mem_valid;
    logic                      mem_ready;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic [WORD_WIDTH-1:0]     mem_data;

    logic                      issue_valid;
    logic [REG_ADDR_WIDTH-1:0] issue_rd;

    logic                      w_en;
    logic [REG_ADDR_WIDTH-1:0] wa3;
    logic [WORD_WIDTH-1:0]     wd3;
    logic [NREGS-1:0]          pending;
    logic [LQ_CNT_WIDTH-1:0]   lq_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd,
        input  alu_ready, mem_ready,
        input  w_en, wa3, wd3, pending, lq_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd,
        output alu_ready, mem_ready,
        output w_en, wa3, wd3, pending, lq_count
    );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Small synchronous FIFO with registered pointers/occupancy and a
// combinational head read; a push while full is only taken alongside a pop.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: flops use non-blocking (<=) so all state updates see pre-edge values; comb uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/reg_writeback.sv
// Sole driver of the register-file write port: arbitrates ALU results against
// buffered load returns, registers the write, and tracks pending destinations.
module reg_writeback
    import reg_writeback_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    reg_writeback_if.slave bus
);

    localparam int ENTRY_W = REG_ADDR_WIDTH + WORD_WIDTH;

    logic                      lq_push, lq_pop, lq_full, lq_empty;
    logic [ENTRY_W-1:0]        lq_wdata, lq_rdata;
    logic [REG_ADDR_WIDTH-1:0] head_rd;
    logic [WORD_WIDTH-1:0]     head_data;

    logic                      sel_fifo, sel_alu;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [WORD_WIDTH-1:0]     sel_data;
    logic                      mem_ready;

    logic                      w_en_q, w_en_d;
    logic [REG_ADDR_WIDTH-1:0] wa3_q, wa3_d;
    logic [WORD_WIDTH-1:0]     wd3_q, wd3_d;
    logic [NREGS-1:0]          pending_q, pending_d;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LQ_DEPTH)
    ) u_load_q (
        .clk   (clk),
        .rst   (rst),
        .push  (lq_push),
        .pop   (lq_pop),
        .wdata (lq_wdata),
        .rdata (lq_rdata),
        .full  (lq_full),
        .empty (lq_empty),
        .count (bus.lq_count)
    );

    assign {head_rd, head_data} = lq_rdata;
    assign lq_wdata = {bus.mem_rd, bus.mem_data};

    // The queue head only preempts the ALU when the ALU is idle or the queue is full.
    always_comb begin
        sel_fifo = !lq_empty && (!bus.alu_valid || lq_full);
        sel_alu  = !sel_fifo && bus.alu_valid;
        sel_rd   = sel_fifo ? head_rd   : bus.alu_rd;
        sel_data = sel_fifo ? head_data : bus.alu_data;
        lq_pop    = sel_fifo;
        mem_ready = !lq_full || lq_pop;
        lq_push   = bus.mem_valid && mem_ready && (bus.mem_rd != '0);
    end

    assign bus.alu_ready = !(lq_full && !lq_empty);
    assign bus.mem_ready = mem_ready;

    always_comb begin
        w_en_d = (sel_fifo || sel_alu) && (sel_rd != '0);
        wa3_d  = wa3_q;
        wd3_d  = wd3_q;
        if (w_en_d) begin
            wa3_d = sel_rd;
            wd3_d = sel_data;
        end
    end

    // Clear on retire, then set on issue, so a same-edge set on one register wins.
    always_comb begin
        pending_d = pending_q;
        if (w_en_d) pending_d[sel_rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) pending_d[bus.issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_en_q    <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
            pending_q <= '0;
        end else begin
            w_en_q    <= w_en_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            pending_q <= pending_d;
        end
    end

    assign bus.w_en    = w_en_q;
    assign bus.wa3     = wa3_q;
    assign bus.wd3     = wd3_q;
    assign bus.pending = pending_q;

endmodule
